// File: rtl/sdram_controller.sv
// rtl/sdram_controller.sv - single-port SDRAM access controller with auto-refresh
//
// Takes over the SDRAM bus once the power-up initializer reports init_fin.
// Serves one-word read/write requests (burst length 2, CAS latency 2 mode
// register assumed) using auto-precharge, and issues periodic auto-refresh.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   init_fin           initializer done (level)
//   req/we/addr/wdata  request: addr = {bank[23:22], row[21:9], col[8:0]}
//   ready              request accepted on an edge where req && ready
//   rdata/rvalid       read data with one-cycle valid pulse
//   done               one-cycle pulse when an access completes
//   DRAM_*             registered SDRAM command/address/mask pins, DQ tristate
module sdram_controller #(
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_RC         = 7,
    parameter int T_WR         = 2,
    parameter int CAS_LAT      = 2,
    parameter int REF_INTERVAL = 750
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_fin,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        done,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_UDQM,
    output logic        DRAM_LDQM,
    inout  wire  [15:0] DRAM_DQ
);

    // {CS, RAS, CAS, WE}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_REF = 4'b0001;

    // Wait counters are loaded on state entry and count down to zero.
    localparam logic [7:0]  RCD_LOAD  = 8'(T_RCD - 1);
    localparam logic [7:0]  RD_LOAD   = 8'(CAS_LAT + T_RP - 1);
    // Counter value in READ_WAIT during the cycle CAS_LAT after READ.
    localparam logic [7:0]  RD_SAMPLE = 8'(T_RP);
    localparam logic [7:0]  WR_LOAD   = 8'(T_WR + T_RP);
    localparam logic [7:0]  RC_LOAD   = 8'(T_RC - 1);
    localparam logic [15:0] REF_LAST  = 16'(REF_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ACTIVATE,
        S_RW,
        S_READ_WAIT,
        S_WRITE_WAIT,
        S_REFRESH
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] ref_cnt_q;
    logic        ref_pending_q;
    logic        we_q;
    logic [1:0]  bank_q;
    logic [8:0]  col_q;
    logic [15:0] wdata_q;
    logic [3:0]  cmd_q;
    logic [12:0] dram_addr_q;
    logic [1:0]  dram_ba_q;
    logic [1:0]  dqm_q;
    logic        dq_oe_q;
    logic [15:0] rdata_q;
    logic        rvalid_q;
    logic        done_q;
    logic        ref_run;

    assign ready = (state_q == S_IDLE) && init_fin && !ref_pending_q;

    // Once started, the refresh timer keeps running even if init_fin drops.
    assign ref_run = (state_q != S_WAIT_INIT) || init_fin;

    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
    assign DRAM_ADDR = dram_addr_q;
    assign DRAM_BA   = dram_ba_q;
    assign {DRAM_UDQM, DRAM_LDQM} = dqm_q;
    assign DRAM_DQ   = dq_oe_q ? wdata_q : 16'hzzzz;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_INIT;
            cnt_q         <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            we_q          <= 1'b0;
            bank_q        <= '0;
            col_q         <= '0;
            wdata_q       <= '0;
            cmd_q         <= CMD_NOP;
            dram_addr_q   <= '0;
            dram_ba_q     <= '0;
            dqm_q         <= 2'b00;
            dq_oe_q       <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Every cycle defaults to NOP with address zero and no data drive.
            cmd_q       <= CMD_NOP;
            dram_addr_q <= '0;
            dram_ba_q   <= '0;
            dqm_q       <= 2'b00;
            dq_oe_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                S_WAIT_INIT: begin
                    if (init_fin) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (ref_pending_q) begin
                        state_q       <= S_REFRESH;
                        cmd_q         <= CMD_REF;
                        cnt_q         <= RC_LOAD;
                        ref_pending_q <= 1'b0;
                    end else if (req && ready) begin
                        we_q        <= we;
                        bank_q      <= addr[23:22];
                        col_q       <= addr[8:0];
                        wdata_q     <= wdata;
                        state_q     <= S_ACTIVATE;
                        cmd_q       <= CMD_ACT;
                        dram_addr_q <= addr[21:9];
                        dram_ba_q   <= addr[23:22];
                        cnt_q       <= RCD_LOAD;
                    end
                end
                S_ACTIVATE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RW;
                        cmd_q       <= we_q ? CMD_WR : CMD_RD;
                        // A10 set selects auto-precharge.
                        dram_addr_q <= {2'b00, 1'b1, 1'b0, col_q};
                        dram_ba_q   <= bank_q;
                        dq_oe_q     <= we_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RW: begin
                    if (we_q) begin
                        // Mask the second beat of the length-2 write burst.
                        state_q <= S_WRITE_WAIT;
                        dqm_q   <= 2'b11;
                        done_q  <= 1'b1;
                        cnt_q   <= WR_LOAD;
                    end else begin
                        state_q <= S_READ_WAIT;
                        cnt_q   <= RD_LOAD;
                    end
                end
                S_READ_WAIT: begin
                    // First burst beat only; the second beat is dropped.
                    if (cnt_q == RD_SAMPLE) begin
                        rdata_q  <= DRAM_DQ;
                        rvalid_q <= 1'b1;
                        done_q   <= 1'b1;
                    end
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else cnt_q <= cnt_q - 8'd1;
                end
                S_WRITE_WAIT, S_REFRESH: begin
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else cnt_q <= cnt_q - 8'd1;
                end
                default: state_q <= S_WAIT_INIT;
            endcase

            // A wrap coinciding with REFRESH entry keeps the new request.
            if (ref_run) begin
                if (ref_cnt_q == REF_LAST) begin
                    ref_cnt_q     <= '0;
                    ref_pending_q <= 1'b1;
                end else begin
                    ref_cnt_q <= ref_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_controller.sv
// tb/tb_sdram_controller.sv - self-checking bench for sdram_controller
module tb_sdram_controller;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] REF = 4'b0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_fin;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        done;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_BA;
    logic        DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic        DRAM_UDQM, DRAM_LDQM;
    wire  [15:0] DRAM_DQ;

    logic        tb_dq_en = 1'b0;
    logic [15:0] tb_dq    = 16'h0000;
    assign DRAM_DQ = tb_dq_en ? tb_dq : 16'hzzzz;

    logic [3:0] cmd;
    assign cmd = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;
    int t_init  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_controller dut (
        .clk(clk), .reset_n(reset_n), .init_fin(init_fin), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .done(done), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA),
        .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N),
        .DRAM_WE_N(DRAM_WE_N), .DRAM_UDQM(DRAM_UDQM), .DRAM_LDQM(DRAM_LDQM),
        .DRAM_DQ(DRAM_DQ)
    );

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] mem;
        logic [1:0]  ba;
        logic [12:0] row;
        logic [12:0] rwa;
        int          pulse;
        int          rdy;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle; the transfer edge ends it.
    task automatic run_vec(input vec_t v);
        logic [3:0] ecmd;
        we = v.we; addr = v.addr; wdata = v.wdata; req = 1'b1;
        chk("vec_ready_c0", ready, 1);
        step();
        // Scramble inputs so that only latched values can be used.
        req = 1'b0; we = ~v.we; addr = ~v.addr; wdata = ~v.wdata;
        for (int k = 1; k <= v.rdy; k++) begin
            if (!v.we) begin
                tb_dq_en = (k >= 4 && k <= 6);
                tb_dq    = (k == 5) ? v.mem : ~v.mem;
            end
            ecmd = (k == 1) ? ACT : (k == 3) ? (v.we ? WR : RD) : NOP;
            chk("vec_cmd", cmd, ecmd);
            chk("vec_ready", ready, (k == v.rdy));
            chk("vec_done", done, (k == v.pulse));
            chk("vec_rvalid", rvalid, (!v.we && k == v.pulse));
            chk("vec_dqm", {DRAM_UDQM, DRAM_LDQM}, (v.we && k == 4) ? 2'b11 : 2'b00);
            if (k == 1) begin
                chk("vec_act_ba", DRAM_BA, v.ba);
                chk("vec_act_row", DRAM_ADDR, v.row);
            end
            if (k == 2) chk("vec_nop_addr", DRAM_ADDR, 0);
            if (k == 3) begin
                chk("vec_rw_ba", DRAM_BA, v.ba);
                chk("vec_rw_addr", DRAM_ADDR, v.rwa);
                if (v.we) chk("vec_wr_dq", DRAM_DQ, v.wdata);
            end
            if (!v.we && k == v.pulse) chk("vec_rdata", rdata, v.mem);
            step();
        end
        tb_dq_en = 1'b0;
    endtask

    task automatic wait_ref(input int exp_cyc);
        int found = -1;
        for (int i = 0; i < 1000 && found < 0; i++) begin
            if (cmd == REF) found = cyc;
            else step();
        end
        chk("ref_cycle", found, exp_cyc);
        if (found >= 0) begin
            chk("ref_ready_r", ready, 0);
            for (int k = 1; k < 7; k++) begin
                step();
                chk("ref_nop", cmd, NOP);
                chk("ref_busy", ready, 0);
            end
            step();
            chk("ref_ready_back", ready, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int b;
        logic [3:0] ecmd;
        vecs[0] = '{1'b1, 24'h5A1234, 16'hBEEF, 16'h0000, 2'd1, 13'h0D09, 13'h0434, 4, 9};
        vecs[1] = '{1'b0, 24'h5A1234, 16'h0000, 16'hBEEF, 2'd1, 13'h0D09, 13'h0434, 6, 8};
        vecs[2] = '{1'b1, 24'hFFFFFF, 16'h0001, 16'h0000, 2'd3, 13'h1FFF, 13'h05FF, 4, 9};
        vecs[3] = '{1'b0, 24'h000000, 16'h0000, 16'h1234, 2'd0, 13'h0000, 13'h0400, 6, 8};
        vecs[4] = '{1'b0, 24'h800200, 16'h0000, 16'hA5C3, 2'd2, 13'h0001, 13'h0400, 6, 8};
        vecs[5] = '{1'b1, 24'h3FFE01, 16'h5555, 16'h0000, 2'd0, 13'h1FFF, 13'h0401, 4, 9};

        reset_n = 1'b0; init_fin = 1'b0; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0;
        step(); step();
        chk("rst_cmd", cmd, NOP);
        chk("rst_addr", DRAM_ADDR, 0);
        chk("rst_ba", DRAM_BA, 0);
        chk("rst_dqm", {DRAM_UDQM, DRAM_LDQM}, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("wait_init_cmd", cmd, NOP);
            chk("wait_init_ready", ready, 0);
        end
        init_fin = 1'b1;
        t_init = cyc;
        chk("init_ready_same", ready, 0);
        step();
        chk("init_ready_next", ready, 1);
        chk("init_cmd", cmd, NOP);

        foreach (vecs[i]) run_vec(vecs[i]);

        wait_ref(t_init + 751);
        wait_ref(t_init + 1501);
        wait_ref(t_init + 2251);

        // Read in flight while the refresh timer wraps, request held high.
        a = t_init + 2996;
        while (cyc < a) step();
        tb_dq_en = 1'b1; tb_dq = 16'h6A6A;
        req = 1'b1; we = 1'b0; addr = 24'h5A1234;
        chk("held_ready_a", ready, 1);
        for (int k = 1; k <= 17; k++) begin
            step();
            ecmd = (k == 1 || k == 17) ? ACT : (k == 3) ? RD : (k == 9) ? REF : NOP;
            chk("held_cmd", cmd, ecmd);
            chk("held_ready", ready, (k == 16));
        end
        req = 1'b0;
        for (int i = 0; i < 20 && !ready; i++) step();
        chk("held_done_ready", ready, 1);
        chk("held_rdata", rdata, 16'h6A6A);

        // Asynchronous reset during READ_WAIT.
        b = cyc;
        req = 1'b1; we = 1'b0; addr = 24'h000100;
        step();
        req = 1'b0;
        step(); step();
        chk("abort_read_cmd", cmd, RD);
        step(); step();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_cycle", cyc, b + 5);
        chk("abort_cmd", cmd, NOP);
        chk("abort_ready", ready, 0);
        chk("abort_rvalid", rvalid, 0);
        chk("abort_done", done, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_addr", DRAM_ADDR, 0);
        chk("abort_ba", DRAM_BA, 0);
        chk("abort_dqm", {DRAM_UDQM, DRAM_LDQM}, 0);
        chk("abort_dq_free", DRAM_DQ, 16'h6A6A);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("abort_no_rvalid", rvalid, 0);
            chk("abort_no_done", done, 0);
            chk("abort_hold_cmd", cmd, NOP);
        end
        reset_n = 1'b1;
        chk("abort_ready_rel", ready, 0);
        step();
        chk("abort_ready_back", ready, 1);
        tb_dq_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
